scroll_strip_layer: RTL and testbench

- Parametrised successor to the fixed ground-strip renderer. Draws a horizontally tiled, integer-scaled bitmap strip that scrolls along paint_y.
- Per-frame scroll speed is signed and can be paused. The scroll phase is kept internally rather than supplied as a shift.
- Sits in the paint pipeline beside the other sprite layers and feeds the layer compositor with paint_enable/paint_color at a fixed latency.

---
 rtl/scroll_strip_layer_pkg.sv | 22 ++
 rtl/rom.sv | 26 ++
 rtl/scroll_phase.sv | 38 +++
 rtl/scroll_strip_layer.sv | 135 +++++++++++++
 tb/tb_scroll_strip_layer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scroll_strip_layer_pkg.sv
// Shared types and constants for the paint-pipeline layers.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package scroll_strip_layer_pkg;

  typedef logic [15:0]        color_t;   // RGB565
  typedef logic signed [15:0] coord_t;   // raster coordinate / phase arithmetic

  // Paint-pipeline latency shared by every layer feeding the compositor.
  localparam int PIPE_LAT = 4;

  // Fold a phase sum that overshot by less than one period back into [0, period).
  function automatic coord_t wrap_phase(input coord_t sum, input coord_t period);
    if (sum[15])
      return sum + period;
    else if (sum >= period)
      return sum - period;
    else
      return sum;
  endfunction

endpackage

// File: rtl/rom.sv
// Generic read-only table with contents baked in via the INIT parameter (entry 0 in the LSBs).
// Latency: 1 clk (registered read); output clears to 0 in reset.
// Backpressure: none; accepts one address per clock.
module rom #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter logic [WIDTH*DEPTH-1:0] INIT = '0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] dout
);

  // Registered read; addresses past the table end read as zero.
  always_ff @(posedge clk) begin
    if (!rstn)
      dout <= '0;
    else if (int'(addr) < DEPTH)
      dout <= INIT[int'(addr)*WIDTH +: WIDTH];
    else
      dout <= '0;
  end

endmodule

// File: rtl/scroll_phase.sv
// Per-frame scroll phase accumulator, kept in [0, PERIOD), signed speed, pausable.
// Latency: phase updates on the clock edge that samples new_frame; phase_next shows it a cycle early.
// Backpressure: none.
module scroll_phase
  import scroll_strip_layer_pkg::*;
#(
  parameter int PERIOD = 28
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              new_frame,
  input  logic signed [7:0] speed,
  input  logic              pause,
  output coord_t            phase,
  output coord_t            phase_next
);

  localparam coord_t PERIOD_C = coord_t'(PERIOD);

  coord_t sum;

  // Value the phase takes at this edge: advance and wrap on an unpaused frame start.
  always_comb begin
    sum        = phase + coord_t'(speed);
    phase_next = phase;
    if (new_frame && !pause)
      phase_next = wrap_phase(sum, PERIOD_C);
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (!rstn)
      phase <= '0;
    else
      phase <= phase_next;
  end

endmodule

// File: rtl/scroll_strip_layer.sv
// Horizontally tiled, integer-scaled bitmap strip that scrolls along paint_y (optional macro SCROLL_STRIP_COLOR_KEY_EN: index 0 transparent).
// Latency: PIPE_LAT (4) clk edges from paint_x/paint_y to paint_enable/paint_color, one pixel per clock.
// Backpressure: none; needs a gap-free raster with x as the inner loop for the line counter.
module scroll_strip_layer
  import scroll_strip_layer_pkg::*;
#(
  parameter int POS        = 128,
  parameter int TILE_W     = 8,
  parameter int TILE_LEN   = 7,
  parameter int SCALE_LOG2 = 2,
  parameter int STRIP_LEN  = 480,
  parameter int IDX_W      = 4,
  parameter int PAL_DEPTH  = 8,
  parameter logic [TILE_W*TILE_LEN*IDX_W-1:0] BITMAP_INIT  = '0,
  parameter logic [PAL_DEPTH*16-1:0]          PALETTE_INIT = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              new_frame,
  input  coord_t            paint_x,
  input  coord_t            paint_y,
  input  logic signed [7:0] speed,
  input  logic              pause,
  output logic              paint_enable,
  output color_t            paint_color
);

  localparam int PERIOD = TILE_LEN << SCALE_LOG2;
  localparam int WCROSS = TILE_W << SCALE_LOG2;
  localparam int DEPTH  = TILE_W * TILE_LEN;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PW     = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;

  coord_t              phase;
  coord_t              phase_next;
  coord_t              u;
  coord_t              u_r;
  logic                act_d;
  logic [PIPE_LAT-1:0] act_sr;     // [0]=act1 .. [PIPE_LAT-1]=act4
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    row;
  logic [15:0]         col_full;
  logic                line_end;
  logic [AW-1:0]       addr;
  logic [IDX_W-1:0]    idx;
  logic                unused_bits;

  scroll_phase #(
    .PERIOD(PERIOD)
  ) u_phase (
    .clk       (clk),
    .rstn      (rstn),
    .new_frame (new_frame),
    .speed     (speed),
    .pause     (pause),
    .phase     (phase),
    .phase_next(phase_next)
  );

  // Cross-axis offset and strip coverage test; the sign bits catch negative coordinates.
  assign u     = paint_x - coord_t'(POS);
  assign act_d = !u[15] && (u < coord_t'(WCROSS)) &&
                 !paint_y[15] && (paint_y < coord_t'(STRIP_LEN));

  assign line_end = act_sr[0] && (u_r == coord_t'(WCROSS - 1));
  assign col_full = u_r >> SCALE_LOG2;
  assign row      = cnt >> SCALE_LOG2;

  // S1/S2 pipeline registers and the coverage flag shifted down to the outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      act_sr <= '0;
      u_r    <= '0;
      addr   <= '0;
    end else begin
      act_sr <= {act_sr[PIPE_LAT-2:0], act_d};
      u_r    <= u;
      addr   <= AW'(col_full) + AW'(int'(row) * TILE_W);
    end
  end

  // Line counter along the strip: reloads from the new phase at frame start
  // (winning over a coincident line end), otherwise steps after each strip line.
  always_ff @(posedge clk) begin
    if (!rstn)
      cnt <= '0;
    else if (new_frame)
      cnt <= phase_next[CNT_W-1:0];
    else if (line_end)
      cnt <= (cnt == CNT_W'(PERIOD - 1)) ? '0 : cnt + CNT_W'(1);
  end

  rom #(
    .WIDTH(IDX_W),
    .DEPTH(DEPTH),
    .INIT (BITMAP_INIT)
  ) u_bitmap (
    .clk (clk),
    .rstn(rstn),
    .addr(addr),
    .dout(idx)
  );

  rom #(
    .WIDTH(16),
    .DEPTH(PAL_DEPTH),
    .INIT (PALETTE_INIT)
  ) u_palette (
    .clk (clk),
    .rstn(rstn),
    .addr(idx[PW-1:0]),
    .dout(paint_color)
  );

`ifdef SCROLL_STRIP_COLOR_KEY_EN
  logic [IDX_W-1:0] idx_s4;

  // Index aligned with the palette output so index 0 can be keyed out.
  always_ff @(posedge clk) begin
    if (!rstn)
      idx_s4 <= '0;
    else
      idx_s4 <= idx;
  end

  assign paint_enable = act_sr[PIPE_LAT-1] && (idx_s4 != '0);
`else
  assign paint_enable = act_sr[PIPE_LAT-1];
`endif

  // Phase is observable for debug only; upper index bits may not reach the palette.
  assign unused_bits = ^{phase, phase_next[15:CNT_W], idx};

endmodule

// File: tb/tb_scroll_strip_layer.sv
module tb_scroll_strip_layer;
  import scroll_strip_layer_pkg::*;

  localparam int POS = 128;
  localparam int TW  = 8;
  localparam int TL  = 7;
  localparam int SL  = 2;
  localparam int PER = 28;
  localparam int IW  = 4;
  localparam int PD  = 8;

  // Bitmap entry: low 3 bits walk with row+col, bit 3 set in right half.
  function automatic logic [3:0] bmp(input int r, input int c);
    return 4'(((r + c) % 8) + ((c >= 4) ? 8 : 0));
  endfunction

  function automatic logic [15:0] pal(input int i);
    return 16'((i + 1) * 32'h1003);
  endfunction

  function automatic logic [TW*TL*IW-1:0] mk_bmp();
    logic [TW*TL*IW-1:0] v;
    v = '0;
    for (int r = 0; r < TL; r++)
      for (int c = 0; c < TW; c++)
        v[(r*TW + c)*IW +: IW] = bmp(r, c);
    return v;
  endfunction

  function automatic logic [PD*16-1:0] mk_pal();
    logic [PD*16-1:0] v;
    v = '0;
    for (int i = 0; i < PD; i++)
      v[i*16 +: 16] = pal(i);
    return v;
  endfunction

  localparam logic [TW*TL*IW-1:0] BMP_INIT = mk_bmp();
  localparam logic [PD*16-1:0]    PAL_INIT = mk_pal();

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              new_frame = 1'b0;
  coord_t            paint_x = '0;
  coord_t            paint_y = '0;
  logic signed [7:0] speed = '0;
  logic              pause = 1'b0;
  logic              paint_enable;
  color_t            paint_color;

  scroll_strip_layer #(
    .BITMAP_INIT (BMP_INIT),
    .PALETTE_INIT(PAL_INIT)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .new_frame   (new_frame),
    .paint_x     (paint_x),
    .paint_y     (paint_y),
    .speed       (speed),
    .pause       (pause),
    .paint_enable(paint_enable),
    .paint_color (paint_color)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          x;
    int          y;
    logic        en;
    logic [15:0] col;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   mp    = 0;   // model phase

  task automatic chk(input string nm, input int got, input int want, input int x, input int y);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s x=%0d y=%0d got=%0h want=%0h", nm, x, y, got, want);
    end
  endtask

  // Apply one pixel for one cycle; optionally schedule its expected response.
  task automatic drive(input int x, input int y, input bit nf, input bit push);
    exp_t e;
    int   u;
    int   row;
    logic [3:0] id;
    @(posedge clk);
    #1;
    paint_x   = 16'(x);
    paint_y   = 16'(y);
    new_frame = nf;
    if (push) begin
      u     = x - POS;
      e.due = cyc + 4;
      e.x   = x;
      e.y   = y;
      e.en  = (u >= 0) && (u < TW*4) && (y >= 0) && (y < 480);
      e.col = '0;
      if (e.en) begin
        row   = ((mp + y) % PER) >> SL;
        id    = bmp(row, u >> SL);
        e.col = pal(int'(id & 4'h7));
`ifdef SCROLL_STRIP_COLOR_KEY_EN
        e.en  = (id != 4'h0);
`endif
      end
      sb.push_back(e);
    end
  endtask

  task automatic line(input int y, input bit push);
    for (int x = 126; x <= 161; x++) drive(x, y, 1'b0, push);
  endtask

  // Frame-start pulse followed by one idle cycle, so phase/cnt are updated on return.
  task automatic frame_start();
    if (!pause) mp = ((mp + int'(speed)) % PER + PER) % PER;
    drive(0, -100, 1'b1, 1'b0);
    drive(0, -100, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout pending=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every cycle, retire expectations that fall due now.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("due_cycle", e.due, cyc, e.x, e.y);
      chk("enable", int'(paint_enable), int'(e.en), e.x, e.y);
      if (e.en) chk("color", int'(paint_color), int'(e.col), e.x, e.y);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with active coordinates.
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(128, 0, 1'b0, 1'b0);
      chk("rst_enable", int'(paint_enable), 0, 128, 0);
      chk("rst_color", int'(paint_color), 0, 128, 0);
      chk("rst_phase", int'(dut.u_phase.phase), 0, 128, 0);
    end
    rstn = 1'b1;

    // Geometry at phase 0, including strip edges and off-strip rows.
    speed = 8'sd0;
    pause = 1'b0;
    frame_start();
    for (int y = 0; y < 3; y++) line(y, 1'b1);
    drive(128, 480, 1'b0, 1'b1);
    drive(140, 480, 1'b0, 1'b1);
    drive(128, -1, 1'b0, 1'b1);
    drive(-3, 0, 1'b0, 1'b1);
    drain();

    // Forward scroll: ten frames at speed 3 -> phase 2.
    speed = 8'sd3;
    for (int f = 0; f < 10; f++) frame_start();
    chk("phase_fwd", int'(dut.u_phase.phase), 2, 0, 0);
    for (int y = 0; y < 4; y++) line(y, 1'b1);
    drain();

    // Reset mid-frame clears phase, line counter and pipeline.
    drive(128, 4, 1'b0, 1'b0);
    drive(129, 4, 1'b0, 1'b0);
    rstn = 1'b0;
    drive(130, 4, 1'b0, 1'b0);
    drive(131, 4, 1'b0, 1'b0);
    chk("midrst_phase", int'(dut.u_phase.phase), 0, 0, 0);
    chk("midrst_cnt", int'(dut.cnt), 0, 0, 0);
    chk("midrst_enable", int'(paint_enable), 0, 0, 0);
    rstn = 1'b1;
    mp = 0;

    // Negative wrap: 0 - 5 -> 23, first line reads row 5.
    speed = -8'sd5;
    frame_start();
    chk("phase_neg", int'(dut.u_phase.phase), 23, 0, 0);
    for (int y = 0; y < 6; y++) line(y, 1'b1);
    drain();

    // Pause holds the phase across frames.
    pause = 1'b1;
    speed = 8'sd7;
    for (int f = 0; f < 5; f++) begin
      frame_start();
      chk("phase_pause", int'(dut.u_phase.phase), 23, 0, f);
    end

    // 28 full lines bring the line counter back to its start, then continue.
    for (int y = 0; y < 28; y++) line(y, 1'b1);
    chk("cnt_wrap", int'(dut.cnt), 23, 0, 28);
    line(28, 1'b1);
    drain();

    // Frame start coincident with a line-end increment: reload wins.
    pause = 1'b0;
    speed = 8'sd4;
    drive(159, 0, 1'b0, 1'b0);
    frame_start();
    chk("cnt_coincident", int'(dut.cnt), 27, 0, 0);
    chk("phase_coincident", int'(dut.u_phase.phase), 27, 0, 0);
    for (int y = 0; y < 2; y++) line(y, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
